// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard and forwarding controller: tracks in-flight destinations,
// raises load-use stalls and registers per-operand forward selections into EX.
module hazard_scoreboard #(
    parameter int REG_BITS   = 5,
    parameter int XLEN       = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                id_valid,
    input  logic [REG_BITS-1:0]                 id_rs1,
    input  logic [REG_BITS-1:0]                 id_rs2,
    input  logic                                id_rs1_used,
    input  logic                                id_rs2_used,
    input  logic [REG_BITS-1:0]                 id_rd,
    input  logic                                id_wr,
    input  logic                                id_load,
    input  logic                                flush,
    input  logic [(DEPTH-1)*LANES*XLEN-1:0]     stg_data,
    output logic                                stall,
    output logic                                ex_fwd_a,
    output logic                                ex_fwd_b,
    output logic [LANES*XLEN-1:0]               ex_data_a,
    output logic [LANES*XLEN-1:0]               ex_data_b,
    output logic [15:0]                         stall_cycles
);

    localparam int unsigned OPW   = LANES * XLEN;
    localparam int unsigned SEL_W = $clog2(DEPTH);
    localparam int unsigned LS    = LOAD_STAGE;

    typedef struct packed {
        logic             haz;
        logic [SEL_W-1:0] sel;
    } res_t;

    logic [DEPTH-1:0]                ent_valid;
    logic [DEPTH-1:0]                ent_load;
    logic [DEPTH-1:0][REG_BITS-1:0]  ent_rd;
    logic [SEL_W-1:0]                sel_a;
    logic [SEL_W-1:0]                sel_b;
    res_t                            res_a;
    res_t                            res_b;
    logic                            hold;

    // Youngest match wins: the scan stops at the first hit from entry 0 upward.
    // The retiring entry (DEPTH-1) is never searched; the regfile is write-through.
    function automatic res_t resolve(
        input logic [REG_BITS-1:0]               src,
        input logic                              used,
        input logic [DEPTH-1:0]                  v,
        input logic [DEPTH-1:0]                  ld,
        input logic [DEPTH-1:0][REG_BITS-1:0]    rd
    );
        res_t r;
        logic found;
        r     = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < DEPTH - 1; j++) begin
            if (!found && used && v[j] && (rd[j] == src) && (src != '0)) begin
                found = 1'b1;
                r.sel = SEL_W'(j + 1);
                r.haz = ld[j] && ((j + 1) < LS);
            end
        end
        return r;
    endfunction

    function automatic logic [OPW-1:0] pick(
        input logic [SEL_W-1:0]                  sel,
        input logic [(DEPTH-1)*OPW-1:0]          data
    );
        logic [OPW-1:0] d;
        d = '0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (sel == SEL_W'(k)) begin
                d = data[k*OPW-1 -: OPW];
            end
        end
        return d;
    endfunction

    always_comb begin
        res_a = resolve(id_rs1, id_rs1_used, ent_valid, ent_load, ent_rd);
        res_b = resolve(id_rs2, id_rs2_used, ent_valid, ent_load, ent_rd);
        stall = id_valid && !flush && (res_a.haz || res_b.haz);
        hold  = stall || flush;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid    <= '0;
            ent_load     <= '0;
            ent_rd       <= '0;
            sel_a        <= '0;
            sel_b        <= '0;
            stall_cycles <= '0;
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_rd[k]    <= ent_rd[k-1];
            end
            ent_valid[0] <= id_valid && id_wr && !hold;
            ent_load[0]  <= id_load;
            ent_rd[0]    <= id_rd;
            sel_a        <= hold ? '0 : res_a.sel;
            sel_b        <= hold ? '0 : res_b.sel;
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    always_comb begin
        ex_fwd_a  = (sel_a != '0);
        ex_fwd_b  = (sel_b != '0);
        ex_data_a = pick(sel_a, stg_data);
        ex_data_b = pick(sel_b, stg_data);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: cycle-accurate issue-history model on the default
// configuration plus a long saturation run on a DEPTH=8 / LOAD_STAGE=7 instance.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int LS    = 2;
    localparam int W     = 128;

    localparam logic [W-1:0] SLOT1 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hDEADBEEF};
    localparam logic [W-1:0] SLOT2 = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // default-configuration DUT
    logic         rst, id_valid, u1, u2, id_wr, id_load, flush;
    logic [4:0]   rs1, rs2, rd;
    logic [2*W-1:0] stg;
    logic         stall, fwd_a, fwd_b;
    logic [W-1:0] data_a, data_b;
    logic [15:0]  cnt;

    hazard_scoreboard #(.REG_BITS(5), .XLEN(32), .LANES(4), .DEPTH(DEPTH), .LOAD_STAGE(LS)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(rs1), .id_rs2(rs2),
        .id_rs1_used(u1), .id_rs2_used(u2), .id_rd(rd), .id_wr(id_wr), .id_load(id_load),
        .flush(flush), .stg_data(stg), .stall(stall), .ex_fwd_a(fwd_a), .ex_fwd_b(fwd_b),
        .ex_data_a(data_a), .ex_data_b(data_b), .stall_cycles(cnt)
    );

    // long-penalty DUT used for counter saturation
    logic           rst2;
    logic [7*W-1:0] stg2 = '0;
    logic           stall2, fwd_a2, fwd_b2;
    logic [W-1:0]   data_a2, data_b2;
    logic [15:0]    cnt2;

    hazard_scoreboard #(.REG_BITS(5), .XLEN(32), .LANES(4), .DEPTH(8), .LOAD_STAGE(7)) dut2 (
        .clk(clk), .rst(rst2), .id_valid(1'b1), .id_rs1(5'd5), .id_rs2(5'd0),
        .id_rs1_used(1'b1), .id_rs2_used(1'b0), .id_rd(5'd5), .id_wr(1'b1), .id_load(1'b1),
        .flush(1'b0), .stg_data(stg2), .stall(stall2), .ex_fwd_a(fwd_a2), .ex_fwd_b(fwd_b2),
        .ex_data_a(data_a2), .ex_data_b(data_b2), .stall_cycles(cnt2)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: hist[0] is the instruction issued last cycle, hist[j] issued j+1 cycles ago.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       ld;
    } rec_t;

    rec_t hist[$];
    int   m_sel_a = 0;
    int   m_sel_b = 0;
    int   m_cnt   = 0;
    bit   model_ok = 0;

    function automatic int age_of(logic [4:0] s, logic used);
        if (!used || s == 5'd0) return -1;
        for (int j = 0; j < DEPTH - 1; j++)
            if (hist[j].v && hist[j].rd == s) return j;
        return -1;
    endfunction

    function automatic bit load_use(int j);
        if (j < 0) return 0;
        return hist[j].ld && (j + 1 < LS);
    endfunction

    function automatic bit m_stall();
        return id_valid && !flush &&
               (load_use(age_of(rs1, u1)) || load_use(age_of(rs2, u2)));
    endfunction

    function automatic logic [W-1:0] slot_of(int k);
        if (k == 0) return '0;
        return stg[(k-1)*W +: W];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            hist.delete();
            for (int i = 0; i < DEPTH; i++) hist.push_back('{0, 5'd0, 0});
            m_sel_a  = 0;
            m_sel_b  = 0;
            m_cnt    = 0;
            model_ok = 1;
        end else if (model_ok) begin
            bit s;
            int ja, jb;
            s  = m_stall();
            ja = age_of(rs1, u1);
            jb = age_of(rs2, u2);
            m_sel_a = (s || flush || ja < 0) ? 0 : ja + 1;
            m_sel_b = (s || flush || jb < 0) ? 0 : jb + 1;
            if (s && m_cnt < 65535) m_cnt++;
            hist.push_front('{id_valid && id_wr && !s && !flush, rd, id_load});
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_stall", W'(stall), W'(m_stall()));
            chk("model_fwd_a", W'(fwd_a), W'(m_sel_a != 0));
            chk("model_fwd_b", W'(fwd_b), W'(m_sel_b != 0));
            chk("model_data_a", data_a, slot_of(m_sel_a));
            chk("model_data_b", data_b, slot_of(m_sel_b));
            chk("model_cnt", W'(cnt), W'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                         input logic [4:0] b, input logic ub, input logic [4:0] d,
                         input logic w, input logic l, input logic f);
        id_valid = v; rs1 = a; u1 = ua; rs2 = b; u2 = ub;
        rd = d; id_wr = w; id_load = l; flush = f;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic main_seq();
        rst = 0; stg = {SLOT2, SLOT1};
        id_valid = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; rd = 0; id_wr = 0; id_load = 0; flush = 0;
        tick(); tick();
        rst = 1;
        idle();
        chk("rst_stall", W'(stall), '0);
        chk("rst_fwd_a", W'(fwd_a), '0);
        chk("rst_fwd_b", W'(fwd_b), '0);
        chk("rst_cnt", W'(cnt), '0);
        tick();

        // ALU producer r3 -> consumer rs1
        drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 0); tick();
        drive(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_no_stall", W'(stall), '0); tick();
        idle();
        chk("alu_fwd_a", W'(fwd_a), W'(1));
        chk("alu_data_a", data_a, SLOT1); tick();

        // load r5 -> consumer rs2: one stall cycle, then slot 2
        drive(1, 0, 0, 0, 0, 5'd5, 1, 1, 0); tick();
        drive(1, 0, 0, 5'd5, 1, 0, 0, 0, 0);
        chk("ld_stall", W'(stall), W'(1)); tick();
        drive(1, 0, 0, 5'd5, 1, 0, 0, 0, 0);
        chk("ld_stall_clear", W'(stall), '0);
        chk("ld_cnt", W'(cnt), W'(1)); tick();
        idle();
        chk("ld_fwd_b", W'(fwd_b), W'(1));
        chk("ld_data_b", data_b, SLOT2); tick();

        // vector v17 then scalar r1; consumer reads v17
        drive(1, 0, 0, 0, 0, 5'b10001, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 5'b00001, 1, 0, 0); tick();
        drive(1, 5'b10001, 1, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("vec_fwd_a", W'(fwd_a), W'(1));
        chk("vec_data_a", data_a, SLOT2); tick();

        // r0 is never forwarded
        drive(1, 0, 0, 0, 0, 5'd0, 1, 0, 0); tick();
        drive(1, 5'd0, 1, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("r0_fwd_a", W'(fwd_a), '0);
        chk("r0_data_a", data_a, '0); tick();

        // two writes to r4: younger one wins
        drive(1, 0, 0, 0, 0, 5'd4, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 5'd4, 1, 0, 0); tick();
        drive(1, 5'd4, 1, 0, 0, 0, 0, 0, 0); tick();
        idle();
        chk("young_fwd_a", W'(fwd_a), W'(1));
        chk("young_data_a", data_a, SLOT1); tick();

        // load r6, flushed reader that also writes r9 (must not be inserted)
        drive(1, 0, 0, 0, 0, 5'd6, 1, 1, 0); tick();
        drive(1, 5'd6, 1, 0, 0, 5'd9, 1, 0, 1);
        chk("flush_no_stall", W'(stall), '0); tick();
        drive(1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        chk("flush_sel_clr", W'(fwd_a), '0);
        chk("flush_cnt", W'(cnt), W'(1)); tick();
        idle();
        chk("flush_no_insert", W'(fwd_a), '0); tick();

        // reset pulsed while stalling
        drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0); tick();
        rst = 0;
        drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 0);
        chk("rstmid_stall", W'(stall), W'(1)); tick();
        rst = 1;
        drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 0);
        chk("rstmid_stall_drop", W'(stall), '0);
        chk("rstmid_cnt", W'(cnt), '0); tick();
        idle(); tick();
    endtask

    // Constant "load r5 reading r5": period of 7 cycles, 6 stalling.
    task automatic sat_seq();
        int c, exp_cnt;
        rst2 = 0;
        tick(); tick();
        rst2 = 1;
        for (c = 0; c < 76480; c++) begin
            @(negedge clk);
            exp_cnt = c - (c + 6) / 7;
            if (exp_cnt > 65535) exp_cnt = 65535;
            chk("sat_stall", W'(stall2), W'((c % 7) != 0));
            chk("sat_fwd_a", W'(fwd_a2), W'(c >= 8 && ((c - 1) % 7) == 0));
            chk("sat_cnt", W'(cnt2), W'(exp_cnt));
            if (c == 14) chk("sat_cnt_c14", W'(cnt2), W'(12));
            tick();
        end
        chk("sat_final", W'(cnt2), W'(16'hFFFF));
    endtask

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
